// File: rtl/nes_bus_pkg.sv
// rtl/nes_bus_pkg.sv - shared types, address map and decode helper for the CPU bus control unit
package nes_bus_pkg;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_PPU,
    SEL_IO,
    SEL_PRG
  } sel_e;

  typedef enum logic [2:0] {
    DMA_IDLE,
    DMA_HALT,
    DMA_ALIGN,
    DMA_READ,
    DMA_WRITE
  } dma_state_e;

  localparam logic [15:0] PPU_BASE          = 16'h2000;
  localparam logic [15:0] IO_BASE           = 16'h4000;
  localparam logic [15:0] OPEN_BASE         = 16'h4018;
  localparam logic [15:0] PRG_BASE          = 16'h8000;
  localparam logic [15:0] DMA_REG_ADDR_DEF  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR_DEF = 16'h2004;
  localparam int          RAM_ADDR_W        = 11;

  // The DMA trigger register sits inside the IO window but is owned by the BCU.
  function automatic sel_e decode_sel(input logic [15:0] addr, input logic [15:0] dma_reg);
    sel_e sel;
    if (addr >= PRG_BASE)       sel = SEL_PRG;
    else if (addr >= OPEN_BASE) sel = SEL_NONE;
    else if (addr >= IO_BASE)   sel = (addr == dma_reg) ? SEL_NONE : SEL_IO;
    else if (addr >= PPU_BASE)  sel = SEL_PPU;
    else                        sel = SEL_RAM;
    return sel;
  endfunction

endpackage

// File: rtl/nes_oam_dma.sv
// rtl/nes_oam_dma.sv - OAM DMA engine: halts the CPU and copies one page to the OAM data port
module nes_oam_dma
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEF,
  parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rnw,
  input  logic [7:0]  cpu_wdata,
  input  logic [7:0]  rd_data,
  output logic [15:0] req_addr,
  output logic        req_rnw,
  output logic [7:0]  req_wdata,
  output logic        req_act,
  output logic        rdy,
  output logic        busy
);

  dma_state_e state_q, state_d;
  logic [7:0] page_q, index_q;
  logic       parity_q;
  logic       trigger;

  assign trigger = !cpu_rnw && (cpu_addr == DMA_REG_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= DMA_IDLE;
      page_q   <= 8'h00;
      index_q  <= 8'h00;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      parity_q <= ~parity_q;
      if (state_q == DMA_IDLE && trigger) begin
        page_q  <= cpu_wdata;
        index_q <= 8'h00;
      end else if (state_q == DMA_WRITE) begin
        index_q <= index_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_addr  = {page_q, index_q};
    req_rnw   = 1'b1;
    req_wdata = 8'h00;
    req_act   = 1'b0;
    rdy       = 1'b0;
    busy      = 1'b1;
    case (state_q)
      DMA_IDLE: begin
        rdy  = 1'b1;
        busy = 1'b0;
        if (trigger) state_d = DMA_HALT;
      end
      // A HALT on a get cycle can read straight away; otherwise burn one cycle to align.
      DMA_HALT:  state_d = parity_q ? DMA_ALIGN : DMA_READ;
      DMA_ALIGN: state_d = DMA_READ;
      DMA_READ: begin
        req_act = 1'b1;
        state_d = DMA_WRITE;
      end
      DMA_WRITE: begin
        req_act   = 1'b1;
        req_addr  = OAM_DATA_ADDR;
        req_rnw   = 1'b0;
        req_wdata = rd_data;
        state_d   = (index_q == 8'hFF) ? DMA_IDLE : DMA_READ;
      end
      default: state_d = DMA_IDLE;
    endcase
  end

endmodule

// File: rtl/nes_bus_ctrl.sv
// rtl/nes_bus_ctrl.sv - CPU bus control unit: bus-owner mux, address decode, read mux and open-bus latch
module nes_bus_ctrl
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEF,
  parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEF
) (
  input  logic        i_clk_cpu,
  input  logic        i_rst,
  input  logic [15:0] i_cpu_addr,
  input  logic        i_cpu_rnw,
  input  logic [7:0]  i_cpu_wdata,
  output logic [7:0]  o_cpu_rdata,
  output logic        o_cpu_rdy,
  output logic [15:0] o_bus_addr,
  output logic        o_bus_rnw,
  output logic [7:0]  o_bus_wdata,
  output logic        o_prg_ce,
  input  logic [7:0]  i_prg_rdata,
  output logic        o_ram_ce,
  input  logic [7:0]  i_ram_rdata,
  output logic        o_ppu_ce,
  input  logic [7:0]  i_ppu_rdata,
  output logic        o_io_ce,
  input  logic [7:0]  i_io_rdata,
  output logic        o_dma_busy
);

  logic [15:0] dma_addr;
  logic        dma_rnw;
  logic [7:0]  dma_wdata;
  logic        dma_act;
  logic        ce_en;
  sel_e        bus_sel, sel_q;
  logic [7:0]  open_bus_q;

  nes_oam_dma #(
    .DMA_REG_ADDR  (DMA_REG_ADDR),
    .OAM_DATA_ADDR (OAM_DATA_ADDR)
  ) u_dma (
    .clk       (i_clk_cpu),
    .rst       (i_rst),
    .cpu_addr  (i_cpu_addr),
    .cpu_rnw   (i_cpu_rnw),
    .cpu_wdata (i_cpu_wdata),
    .rd_data   (o_cpu_rdata),
    .req_addr  (dma_addr),
    .req_rnw   (dma_rnw),
    .req_wdata (dma_wdata),
    .req_act   (dma_act),
    .rdy       (o_cpu_rdy),
    .busy      (o_dma_busy)
  );

  // HALT/ALIGN cycles own the bus but must not strobe any target.
  always_comb begin
    if (o_dma_busy) begin
      o_bus_addr  = dma_addr;
      o_bus_rnw   = dma_rnw;
      o_bus_wdata = dma_wdata;
      ce_en       = dma_act;
    end else begin
      o_bus_addr  = i_cpu_addr;
      o_bus_rnw   = i_cpu_rnw;
      o_bus_wdata = i_cpu_wdata;
      ce_en       = 1'b1;
    end
    bus_sel = (ce_en && !i_rst) ? decode_sel(o_bus_addr, DMA_REG_ADDR) : SEL_NONE;
  end

  assign o_prg_ce = (bus_sel == SEL_PRG);
  assign o_ram_ce = (bus_sel == SEL_RAM);
  assign o_ppu_ce = (bus_sel == SEL_PPU);
  assign o_io_ce  = (bus_sel == SEL_IO);

  always_comb begin
    case (sel_q)
      SEL_RAM: o_cpu_rdata = i_ram_rdata;
      SEL_PPU: o_cpu_rdata = i_ppu_rdata;
      SEL_IO:  o_cpu_rdata = i_io_rdata;
      SEL_PRG: o_cpu_rdata = i_prg_rdata;
      default: o_cpu_rdata = open_bus_q;
    endcase
  end

  always_ff @(posedge i_clk_cpu or posedge i_rst) begin
    if (i_rst) begin
      sel_q      <= SEL_NONE;
      open_bus_q <= 8'h00;
    end else begin
      sel_q <= o_bus_rnw ? bus_sel : SEL_NONE;
      if (!o_bus_rnw) open_bus_q <= o_bus_wdata;
      else if (sel_q != SEL_NONE) open_bus_q <= o_cpu_rdata;
    end
  end

endmodule

// File: tb/tb_nes_bus_ctrl.sv
// tb/tb_nes_bus_ctrl.sv - directed self-checking bench for nes_bus_ctrl
module tb_nes_bus_ctrl;
  import nes_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_rnw = 1'b1;
  logic [7:0]  cpu_wdata = 8'h00;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdy;
  logic [15:0] bus_addr;
  logic        bus_rnw;
  logic [7:0]  bus_wdata;
  logic        prg_ce, ram_ce, ppu_ce, io_ce;
  logic [7:0]  prg_rdata = 8'h00, ram_rdata = 8'h00, ppu_rdata = 8'h00, io_rdata = 8'h00;
  logic        dma_busy;
  logic [3:0]  ces;
  logic [7:0]  mem [0:(1<<RAM_ADDR_W)-1];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  assign ces = {prg_ce, ram_ce, ppu_ce, io_ce};

  nes_bus_ctrl dut (
    .i_clk_cpu   (clk),
    .i_rst       (rst),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_rnw   (cpu_rnw),
    .i_cpu_wdata (cpu_wdata),
    .o_cpu_rdata (cpu_rdata),
    .o_cpu_rdy   (cpu_rdy),
    .o_bus_addr  (bus_addr),
    .o_bus_rnw   (bus_rnw),
    .o_bus_wdata (bus_wdata),
    .o_prg_ce    (prg_ce),
    .i_prg_rdata (prg_rdata),
    .o_ram_ce    (ram_ce),
    .i_ram_rdata (ram_rdata),
    .o_ppu_ce    (ppu_ce),
    .i_ppu_rdata (ppu_rdata),
    .o_io_ce     (io_ce),
    .i_io_rdata  (io_rdata),
    .o_dma_busy  (dma_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input logic [10:0] a);
    return (a[7:0] * 8'd7) ^ 8'h3C;
  endfunction

  // Target stubs with one-cycle registered reads.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < (1 << RAM_ADDR_W); i++) mem[i] <= pat(11'(i));
    end else begin
      if (ram_ce) begin
        if (bus_rnw) ram_rdata <= mem[bus_addr[RAM_ADDR_W-1:0]];
        else mem[bus_addr[RAM_ADDR_W-1:0]] <= bus_wdata;
      end
      if (prg_ce) prg_rdata <= bus_addr[15:8] ^ 8'hFF;
      if (ppu_ce) ppu_rdata <= 8'h20 | {5'b0, bus_addr[2:0]};
      if (io_ce)  io_rdata  <= 8'h40 ^ {3'b0, bus_addr[4:0]};
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_cycle(input logic [15:0] a, input logic rnw, input logic [7:0] wd);
    @(negedge clk);
    cpu_addr = a; cpu_rnw = rnw; cpu_wdata = wd;
    #1;
  endtask

  task automatic dma_run(input logic want_parity, input int abort_at);
    int stall, first_rd, j;
    bit done;
    logic [15:0] ea;
    @(negedge clk);
    if (cyc[0] != want_parity) begin
      cpu_addr = 16'h5000; cpu_rnw = 1'b1; cpu_wdata = 8'h00;
      @(negedge clk);
    end
    cpu_addr = DMA_REG_ADDR_DEF; cpu_rnw = 1'b0; cpu_wdata = 8'h02;
    #1;
    chk("dma_trigger_no_ce", {28'h0, ces}, 32'h0);
    chk("dma_trigger_rdy", {31'h0, cpu_rdy}, 32'h1);
    first_rd = want_parity ? 2 : 3;
    stall = 0;
    done = 0;
    for (int k = 1; k <= 600 && !done; k++) begin
      cpu_cycle(16'h5000, 1'b1, 8'h00);
      if (abort_at >= 0 && k == first_rd + 2 * abort_at) begin
        chk("abort_read_addr", {16'h0, bus_addr}, {16'h0, 16'h0200 + 16'(abort_at)});
        rst = 1'b1;
        #1;
        chk("abort_rdy_busy", {30'h0, cpu_rdy, dma_busy}, 32'h2);
        chk("abort_ces", {28'h0, ces}, 32'h0);
        done = 1;
      end else if (cpu_rdy) begin
        done = 1;
      end else begin
        stall++;
        if (k < first_rd) begin
          chk("dma_halt", {27'h0, ces, dma_busy}, 32'h1);
        end else begin
          j  = (k - first_rd) / 2;
          ea = 16'h0200 + 16'(j);
          if (((k - first_rd) % 2) == 0)
            chk("dma_read", {11'h0, ces, bus_rnw, bus_addr}, {11'h0, 4'b0100, 1'b1, ea});
          else
            chk("dma_write", {3'h0, ces, bus_rnw, bus_addr, bus_wdata},
                {3'h0, 4'b0010, 1'b0, 16'h2004, pat(ea[10:0])});
        end
      end
    end
    if (abort_at < 0) begin
      chk("dma_stall_len", 32'(stall), want_parity ? 32'd513 : 32'd514);
      chk("dma_done_rdy_busy", {30'h0, cpu_rdy, dma_busy}, 32'h2);
    end
  endtask

  initial begin
    rst = 1'b1;
    cpu_addr = 16'h0000; cpu_rnw = 1'b1; cpu_wdata = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_rdy_busy", {30'h0, cpu_rdy, dma_busy}, 32'h2);
    chk("reset_ces", {28'h0, ces}, 32'h0);
    chk("reset_rdata", {24'h0, cpu_rdata}, 32'h0);
    rst = 1'b0;

    cpu_cycle(16'hFFFC, 1'b1, 8'h00);
    chk("prg_ce", {28'h0, ces}, 32'h8);
    chk("prg_addr", {16'h0, bus_addr}, 32'hFFFC);
    cpu_cycle(16'h0003, 1'b0, 8'hA5);
    chk("prg_rdata", {24'h0, cpu_rdata}, 32'h00);
    chk("ram_wr_ce", {28'h0, ces}, 32'h4);
    chk("ram_wr_bus", {20'h0, bus_rnw, bus_addr[10:0]}, {20'h0, 1'b0, 11'h003});
    chk("ram_wr_data", {24'h0, bus_wdata}, 32'hA5);
    cpu_cycle(16'h1803, 1'b1, 8'h00);
    chk("ram_mirror_ce", {28'h0, ces}, 32'h4);
    chk("ram_mirror_addr", {21'h0, bus_addr[10:0]}, 32'h003);
    cpu_cycle(16'h2000, 1'b0, 8'h5C);
    chk("ram_mirror_rdata", {24'h0, cpu_rdata}, 32'hA5);
    chk("ppu_ce", {28'h0, ces}, 32'h2);
    cpu_cycle(16'h5000, 1'b1, 8'h00);
    chk("unmapped_ces", {28'h0, ces}, 32'h0);
    cpu_cycle(16'h8123, 1'b1, 8'h00);
    chk("open_bus_write", {24'h0, cpu_rdata}, 32'h5C);
    chk("prg_ce_2", {28'h0, ces}, 32'h8);
    cpu_cycle(16'h4016, 1'b1, 8'h00);
    chk("prg_rdata_2", {24'h0, cpu_rdata}, 32'h7E);
    chk("io_ce", {28'h0, ces}, 32'h1);
    cpu_cycle(16'h4018, 1'b1, 8'h00);
    chk("io_rdata", {24'h0, cpu_rdata}, 32'h56);
    chk("io_edge_ces", {28'h0, ces}, 32'h0);
    cpu_cycle(16'h5000, 1'b1, 8'h00);
    chk("open_bus_read", {24'h0, cpu_rdata}, 32'h56);

    dma_run(1'b1, -1);
    dma_run(1'b0, -1);
    dma_run(1'b1, 8'h40);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cpu_cycle(16'h5000, 1'b1, 8'h00);
      chk("post_abort_ces", {28'h0, ces}, 32'h0);
      chk("post_abort_rdy", {31'h0, cpu_rdy}, 32'h1);
    end
    chk("post_abort_rdata", {24'h0, cpu_rdata}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
